lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 134 +++++++++++++
 tb/tb_lsu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit between the CPU and a word-wide data memory with a one-cycle read latency.
// Handles byte/halfword lane select, sign extension and read-modify-write; misaligned requests are rejected.
module lsu (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        AlignErr,
  output logic [31:0] RData,
  output logic [29:0] Ad,
  output logic [31:0] WrData,
  output logic        DMWr,
  input  logic [31:0] DM
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_off;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [15:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [29:0] r_ad;
  logic [31:0] r_wrdata;

  logic        w_accept;
  logic        w_misalign;
  logic        w_word_st;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_accept   = (r_state == S_IDLE) && Req;
  assign w_misalign = (Size == 2'b11) ||
                      ((Size == SZ_HALF) && Addr[0]) ||
                      ((Size == SZ_WORD) && (Addr[1:0] != 2'b00));
  assign w_word_st  = We && (Size == SZ_WORD);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          if (w_misalign)     w_next = S_DONE;
          else if (w_word_st) w_next = S_WR;
          else                w_next = S_RD;
        end
      end
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = r_we ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads; DM is valid while in CAP.
  always_comb begin
    w_byte = DM[{r_off, 3'b000} +: 8];
    w_half = DM[{r_off[1], 4'b0000} +: 16];
    w_load = DM;
    case (r_size)
      SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = DM;
    endcase
  end

  always_comb begin
    w_merge = DM;
    case (r_size)
      SZ_BYTE: w_merge[{r_off, 3'b000} +: 8]     = r_wdata[7:0];
      SZ_HALF: w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
      default: w_merge = DM;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_off    <= 2'b00;
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_wdata  <= 16'h0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
      r_ad     <= 30'h0;
      r_wrdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_off    <= Addr[1:0];
        r_we     <= We;
        r_size   <= Size;
        r_signed <= Signed;
        r_wdata  <= WData[15:0];
        r_err    <= w_misalign;
        if (!w_misalign) begin
          r_ad <= Addr[31:2];
          if (w_word_st) r_wrdata <= WData;
        end
      end
      if (r_state == S_CAP) begin
        if (r_we) r_wrdata <= w_merge;
        else      r_rdata  <= w_load;
      end
    end
  end

  assign Busy     = (r_state != S_IDLE);
  assign Done     = (r_state == S_DONE);
  assign AlignErr = (r_state == S_DONE) && r_err;
  assign DMWr     = (r_state == S_WR);
  assign RData    = r_rdata;
  assign Ad       = r_ad;
  assign WrData   = r_wrdata;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases with literal expectations plus random traffic against a transaction-level model.
module tb_lsu;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic        We;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Busy;
  logic        Done;
  logic        AlignErr;
  logic [31:0] RData;
  logic [29:0] Ad;
  logic [31:0] WrData;
  logic        DMWr;
  logic [31:0] DM;

  lsu dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done), .AlignErr(AlignErr),
    .RData(RData), .Ad(Ad), .WrData(WrData), .DMWr(DMWr), .DM(DM)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Data memory seen by the DUT: registered read, so DM follows Ad by one cycle.
  logic [31:0] dmem [16];
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_val;

  always @(posedge Clk) begin
    if (ld_en)     dmem[ld_idx] <= ld_val;
    else if (DMWr) dmem[Ad[3:0]] <= WrData;
    DM <= dmem[Ad[3:0]];
  end

  // Transaction-level reference.
  logic [31:0] refm [16];
  bit          m_active;
  int          m_cyc;
  int          m_lat;
  bit          m_we;
  logic [1:0]  m_size;
  bit          m_sgn;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_err;
  logic [31:0] exp_rdata;
  logic [29:0] exp_ad;
  logic [31:0] exp_wrdata;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] sz);
    return (nbytes(sz) == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes(sz))) - 32'h1);
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz,
                                           input bit sgn, input logic [31:0] a);
    logic [31:0] v;
    v = (w >> (8 * (a % 4))) & lane_mask(sz);
    if (sgn && nbytes(sz) < 4 && ((v >> (8 * nbytes(sz) - 1)) & 32'h1) != 0)
      v = v | ~lane_mask(sz);
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [31:0] wd, input logic [31:0] a);
    logic [31:0] m;
    m = lane_mask(sz) << (8 * (a % 4));
    return (w & ~m) | ((wd << (8 * (a % 4))) & m);
  endfunction

  task automatic model_step();
    if (!m_err && m_we && m_cyc == m_lat - 1)
      exp_wrdata = (m_size == 2'd2) ? m_wdata : merge(refm[m_addr[5:2]], m_size, m_wdata, m_addr);
    if (!m_err && m_cyc == m_lat) begin
      if (m_we) refm[m_addr[5:2]] = exp_wrdata;
      else      exp_rdata = fmt_load(refm[m_addr[5:2]], m_size, m_sgn, m_addr);
    end
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (ld_en && !$isunknown(ld_idx) && Clk) refm[ld_idx] = ld_val;
    if (Reset) begin
      m_active   = 1'b0;
      m_cyc      = 0;
      exp_rdata  = 32'h0;
      exp_ad     = 30'h0;
      exp_wrdata = 32'h0;
    end else if (m_active) begin
      if (m_cyc == m_lat) m_active = 1'b0;
      else begin
        m_cyc++;
        model_step();
      end
    end else if (Req) begin
      m_we    = We;
      m_size  = Size;
      m_sgn   = Signed;
      m_addr  = Addr;
      m_wdata = WData;
      m_err   = misaligned(Size, Addr);
      m_lat   = m_err ? 1 : !We ? 3 : (Size == 2'd2) ? 2 : 4;
      m_cyc   = 1;
      m_active = 1'b1;
      if (!m_err) exp_ad = Addr[31:2];
      model_step();
    end
  end

  always @(negedge Clk) begin
    bit e_done;
    bit e_wr;
    if (!Reset) begin
      e_done = m_active && (m_cyc == m_lat);
      e_wr   = m_active && !m_err && m_we && (m_cyc == m_lat - 1);
      chk("busy",     {31'h0, Busy},     {31'h0, m_active});
      chk("done",     {31'h0, Done},     {31'h0, e_done});
      chk("alignerr", {31'h0, AlignErr}, {31'h0, e_done && m_err});
      chk("dmwr",     {31'h0, DMWr},     {31'h0, e_wr});
      chk("rdata",    RData,             exp_rdata);
      chk("ad",       {2'b00, Ad},       {2'b00, exp_ad});
      if (e_wr || !m_active) chk("wrdata", WrData, exp_wrdata);
      if (e_done && m_we && !m_err) chk("memword", dmem[m_addr[5:2]], refm[m_addr[5:2]]);
    end
  end

  int lat, wr_cnt, wr_cyc, aerr_seen;
  logic [29:0] wr_ad;

  task automatic do_req(input bit we, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] a, input logic [31:0] wd);
    We = we; Size = sz; Signed = sgn; Addr = a; WData = wd; Req = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    lat = 0; wr_cnt = 0; wr_cyc = 0; aerr_seen = 0; wr_ad = 30'h0;
    for (int k = 1; k <= 10; k++) begin
      if (DMWr) begin wr_cnt++; wr_cyc = k; wr_ad = Ad; end
      if (Done) begin lat = k; aerr_seen = AlignErr; break; end
      @(negedge Clk);
    end
    if (lat == 0) chk("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    Reset = 1'b1; Req = 1'b0; We = 1'b0; Size = 2'd0; Signed = 1'b0;
    Addr = 32'h0; WData = 32'h0; ld_en = 1'b0; ld_idx = 4'h0; ld_val = 32'h0;
    #1;
    chk("reset_busy",  {31'h0, Busy}, 32'h0);
    chk("reset_rdata", RData, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      ld_en = 1'b1; ld_idx = 4'(i);
      ld_val = (i == 4) ? 32'h8070_60F0 : $urandom;
    end
    @(negedge Clk);
    ld_en = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);

    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
    chk("ldb_s_lat", lat, 3);
    chk("ldb_s_val", RData, 32'hFFFF_FFF0);
    @(negedge Clk);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    chk("ldb_u_val", RData, 32'h0000_00F0);
    @(negedge Clk);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    chk("ldh_s_val", RData, 32'hFFFF_8070);
    @(negedge Clk);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("ldw_val", RData, 32'h8070_60F0);
    @(negedge Clk);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
    chk("stb_lat", lat, 4);
    chk("stb_wrcnt", wr_cnt, 1);
    chk("stb_mem", dmem[4], 32'h8070_ABF0);
    @(negedge Clk);
    do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h1234_5678);
    chk("stw_lat", lat, 2);
    chk("stw_wrcyc", wr_cyc, 1);
    chk("stw_ad", {2'b00, wr_ad}, 32'h5);
    chk("stw_mem", dmem[5], 32'h1234_5678);
    @(negedge Clk);
    do_req(1'b0, 2'd1, 1'b1, 32'h13, 32'h0);
    chk("mis_lat", lat, 1);
    chk("mis_aerr", aerr_seen, 1);
    chk("mis_wrcnt", wr_cnt, 0);
    chk("mis_rdata", RData, 32'h8070_60F0);
    @(negedge Clk);

    // Abort a partial store while it sits in CAP.
    We = 1'b1; Size = 2'd0; Signed = 1'b0; Addr = 32'h10; WData = 32'h0000_00CD; Req = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("rst_busy",  {31'h0, Busy}, 32'h0);
    chk("rst_done",  {31'h0, Done}, 32'h0);
    chk("rst_dmwr",  {31'h0, DMWr}, 32'h0);
    chk("rst_rdata", RData, 32'h0);
    chk("rst_ad",    {2'b00, Ad}, 32'h0);
    chk("rst_wrdat", WrData, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    wr_cnt = 0; lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (DMWr) wr_cnt++;
      if (Done) lat++;
    end
    chk("abort_wr",   wr_cnt, 0);
    chk("abort_done", lat, 0);
    chk("abort_mem",  dmem[4], 32'h8070_ABF0);

    for (int i = 0; i < 600; i++) begin
      Req    = ($urandom_range(0, 2) != 0);
      We     = $urandom_range(0, 1) != 0;
      Size   = 2'($urandom_range(0, 3));
      Signed = $urandom_range(0, 1) != 0;
      Addr   = $urandom;
      WData  = $urandom;
      @(negedge Clk);
    end
    Req = 1'b0;
    repeat (6) @(negedge Clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
